command_parse_and_encapsulate_regfile: RTL and testbench



---
 rtl/command_parse_and_encapsulate_regfile_pkg.sv | 36 +++
 rtl/command_parse_and_encapsulate_regfile_sat_counter.sv | 36 +++
 rtl/command_parse_and_encapsulate_regfile.sv | 159 +++++++++++++++
 tb/tb_command_parse_and_encapsulate_regfile.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/command_parse_and_encapsulate_regfile_pkg.sv
// Shared definitions for the command-bus register slave: bus width defaults,
// window offset map and command class encoding.
package command_parse_and_encapsulate_regfile_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_WR      = 2'd1,
        CMD_RD      = 2'd2,
        CMD_ILLEGAL = 2'd3
    } cmd_class_e;

    // Window layout: config words, then status words, then three control words.
    function automatic int cfg_base();
        return 0;
    endfunction

    function automatic int stat_base(input int n);
        return n;
    endfunction

    function automatic int cmd_cnt_ofs(input int n, input int s);
        return n + s;
    endfunction

    function automatic int err_cnt_ofs(input int n, input int s);
        return n + s + 1;
    endfunction

    function automatic int commit_ofs(input int n, input int s);
        return n + s + 2;
    endfunction

endpackage

// File: rtl/command_parse_and_encapsulate_regfile_sat_counter.sv
// Saturating up-counter with a dominant synchronous clear.
module cpe_sat_counter
    import command_parse_and_encapsulate_regfile_pkg::*;
#(
    parameter int P_DATA_W = DATA_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_inc,
    input  logic                i_clr,
    output logic [P_DATA_W-1:0] ov_cnt
);

    logic [P_DATA_W-1:0] cnt_q;
    logic [P_DATA_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ov_cnt = cnt_q;

endmodule

// File: rtl/command_parse_and_encapsulate_regfile.sv
// Register slave on the management command bus: shadowed config with commit,
// read-only status, command/error counters, one-cycle read response.
module command_parse_and_encapsulate_regfile
    import command_parse_and_encapsulate_regfile_pkg::*;
#(
    parameter int                  P_ADDR_W    = ADDR_W_DEF,
    parameter int                  P_DATA_W    = DATA_W_DEF,
    parameter logic [P_ADDR_W-1:0] P_BASE_ADDR = '0,
    parameter int                  P_REG_NUM   = 8,
    parameter int                  P_STAT_NUM  = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [P_ADDR_W-1:0]             iv_addr,
    input  logic                            i_addr_fixed,
    input  logic [P_DATA_W-1:0]             iv_wdata,
    input  logic                            i_wr,
    input  logic                            i_rd,
    input  logic [P_STAT_NUM*P_DATA_W-1:0]  iv_status,
    output logic [P_REG_NUM*P_DATA_W-1:0]   ov_cfg,
    output logic                            o_cfg_update,
    output logic                            o_wr,
    output logic [P_ADDR_W-1:0]             ov_addr,
    output logic                            o_addr_fixed,
    output logic [P_DATA_W-1:0]             ov_rdata
);

    localparam int L_STAT_BASE = stat_base(P_REG_NUM);
    localparam int L_CMD_OFS   = cmd_cnt_ofs(P_REG_NUM, P_STAT_NUM);
    localparam int L_ERR_OFS   = err_cnt_ofs(P_REG_NUM, P_STAT_NUM);
    localparam int L_COMMIT    = commit_ofs(P_REG_NUM, P_STAT_NUM);

    logic [P_REG_NUM-1:0][P_DATA_W-1:0] shadow_q, shadow_d;
    logic [P_REG_NUM-1:0][P_DATA_W-1:0] active_q, active_d;
    logic                               pending_q, pending_d;
    logic                               cfg_update_q, cfg_update_d;
    logic                               rsp_vld_q, rsp_vld_d;
    logic [P_ADDR_W-1:0]                rsp_addr_q, rsp_addr_d;
    logic [P_DATA_W-1:0]                rsp_data_q, rsp_data_d;

    logic [P_ADDR_W-1:0] offset;
    logic                hit;
    cmd_class_e          cmd_class;
    logic                is_stat, is_cmd, is_err, is_commit;
    logic [P_DATA_W-1:0] rd_word;
    logic [P_DATA_W-1:0] cmd_cnt, err_cnt;
    logic                cmd_inc, err_inc, err_clr;

    always_comb begin
        offset    = iv_addr - P_BASE_ADDR;
        hit       = i_addr_fixed && (iv_addr >= P_BASE_ADDR) && (offset < P_ADDR_W'(L_COMMIT + 1));
        is_stat   = (offset >= P_ADDR_W'(L_STAT_BASE)) && (offset < P_ADDR_W'(L_CMD_OFS));
        is_cmd    = (offset == P_ADDR_W'(L_CMD_OFS));
        is_err    = (offset == P_ADDR_W'(L_ERR_OFS));
        is_commit = (offset == P_ADDR_W'(L_COMMIT));

        cmd_class = CMD_NONE;
        if (hit) begin
            case ({i_wr, i_rd})
                2'b10:   cmd_class = CMD_WR;
                2'b01:   cmd_class = CMD_RD;
                2'b11:   cmd_class = CMD_ILLEGAL;
                default: cmd_class = CMD_NONE;
            endcase
        end
    end

    // Counter reads see the pre-update value because the counters are registered.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < P_REG_NUM; k++) begin
            if (offset == P_ADDR_W'(cfg_base() + k)) rd_word = shadow_q[k];
        end
        for (int k = 0; k < P_STAT_NUM; k++) begin
            if (offset == P_ADDR_W'(L_STAT_BASE + k)) rd_word = iv_status[k*P_DATA_W +: P_DATA_W];
        end
        if (is_cmd)    rd_word = cmd_cnt;
        if (is_err)    rd_word = err_cnt;
        if (is_commit) rd_word = P_DATA_W'(pending_q);
    end

    always_comb begin
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        cfg_update_d = 1'b0;
        rsp_vld_d    = 1'b0;
        rsp_addr_d   = '0;
        rsp_data_d   = '0;

        if (cmd_class == CMD_WR) begin
            for (int k = 0; k < P_REG_NUM; k++) begin
                if (offset == P_ADDR_W'(cfg_base() + k)) begin
                    shadow_d[k] = iv_wdata;
                    pending_d   = 1'b1;
                end
            end
            if (is_commit) begin
                active_d     = shadow_q;
                pending_d    = 1'b0;
                cfg_update_d = 1'b1;
            end
        end

        if (cmd_class == CMD_RD) begin
            rsp_vld_d  = 1'b1;
            rsp_addr_d = iv_addr;
            rsp_data_d = rd_word;
        end
    end

    assign cmd_inc = (cmd_class != CMD_NONE);
    assign err_inc = (cmd_class == CMD_ILLEGAL) || ((cmd_class == CMD_WR) && (is_stat || is_cmd));
    assign err_clr = (cmd_class == CMD_WR) && is_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            cfg_update_q <= 1'b0;
            rsp_vld_q    <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_data_q   <= '0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            cfg_update_q <= cfg_update_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    cpe_sat_counter #(.P_DATA_W(P_DATA_W)) u_cmd_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (cmd_inc),
        .i_clr   (1'b0),
        .ov_cnt  (cmd_cnt)
    );

    cpe_sat_counter #(.P_DATA_W(P_DATA_W)) u_err_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (err_inc),
        .i_clr   (err_clr),
        .ov_cnt  (err_cnt)
    );

    assign ov_cfg       = active_q;
    assign o_cfg_update = cfg_update_q;
    assign o_wr         = rsp_vld_q;
    assign ov_addr      = rsp_addr_q;
    assign o_addr_fixed = rsp_vld_q;
    assign ov_rdata     = rsp_data_q;

endmodule

// File: tb/tb_command_parse_and_encapsulate_regfile.sv
// Directed bench: base 0x0100, 8 config words, 4 status words (COMMIT at 0x010E).
module tb_command_parse_and_encapsulate_regfile;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [18:0]   addr = '0;
    logic          addr_fixed = 1'b0;
    logic [31:0]   wdata = '0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [127:0]  status = '0;
    logic [255:0]  cfg;
    logic          cfg_update;
    logic          rsp_wr;
    logic [18:0]   rsp_addr;
    logic          rsp_fixed;
    logic [31:0]   rsp_data;

    int errors = 0;
    int checks = 0;

    command_parse_and_encapsulate_regfile #(
        .P_ADDR_W    (19),
        .P_DATA_W    (32),
        .P_BASE_ADDR (19'h0100),
        .P_REG_NUM   (8),
        .P_STAT_NUM  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .iv_addr      (addr),
        .i_addr_fixed (addr_fixed),
        .iv_wdata     (wdata),
        .i_wr         (wr),
        .i_rd         (rd),
        .iv_status    (status),
        .ov_cfg       (cfg),
        .o_cfg_update (cfg_update),
        .o_wr         (rsp_wr),
        .ov_addr      (rsp_addr),
        .o_addr_fixed (rsp_fixed),
        .ov_rdata     (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one command for one cycle; returns 1 ns after the capturing edge.
    task automatic issue(input logic [18:0] a, input logic fx, input logic w,
                         input logic r, input logic [31:0] d);
        @(negedge clk);
        addr = a; addr_fixed = fx; wr = w; rd = r; wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; addr_fixed = 1'b0;
        $display("cmd addr=0x%05h fixed=%0d wr=%0d rd=%0d wdata=0x%08h -> o_wr=%0d addr=0x%05h rdata=0x%08h",
                 a, fx, w, r, d, rsp_wr, rsp_addr, rsp_data);
    endtask

    task automatic write_reg(input logic [18:0] a, input logic [31:0] d);
        issue(a, 1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic read_chk(input string tag, input logic [18:0] a, input logic [31:0] exp);
        issue(a, 1'b1, 1'b0, 1'b1, 32'h0);
        check({tag, ".o_wr"}, 64'(rsp_wr), 64'd1);
        check({tag, ".addr"}, 64'(rsp_addr), 64'(a));
        check({tag, ".rdata"}, 64'(rsp_data), 64'(exp));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.o_wr", 64'(rsp_wr), 64'd0);
        check("rst.fixed", 64'(rsp_fixed), 64'd0);
        check("rst.rdata", 64'(rsp_data), 64'd0);
        check("rst.update", 64'(cfg_update), 64'd0);
        check("rst.cfg_lo", cfg[63:0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Shadow write then read-back; active copy untouched
        write_reg(19'h0102, 32'hA5A5_0001);
        check("wr.no_rsp", 64'(rsp_wr), 64'd0);
        read_chk("shadow", 19'h0102, 32'hA5A5_0001);
        check("shadow.fixed", 64'(rsp_fixed), 64'd1);
        check("shadow.cfg2", 64'(cfg[64 +: 32]), 64'd0);
        read_chk("pending1", 19'h010E, 32'h1);

        // Commit
        write_reg(19'h010E, 32'h0);
        check("commit.cfg2", 64'(cfg[64 +: 32]), 64'hA5A5_0001);
        check("commit.update", 64'(cfg_update), 64'd1);
        @(posedge clk);
        #1;
        check("commit.update_pulse", 64'(cfg_update), 64'd0);
        read_chk("pending0", 19'h010E, 32'h0);

        // Status read and illegal status write
        status[32 +: 32] = 32'h1234_5678;
        read_chk("status1", 19'h0109, 32'h1234_5678);
        write_reg(19'h0109, 32'hFFFF_FFFF);
        read_chk("err_after_stat_wr", 19'h010D, 32'd1);
        // Hits so far: 8 before this read
        read_chk("cmd_cnt_a", 19'h010C, 32'd8);

        // Misses
        issue(19'h0100, 1'b0, 1'b0, 1'b1, 32'h0);
        check("miss_table.o_wr", 64'(rsp_wr), 64'd0);
        check("miss_table.rdata", 64'(rsp_data), 64'd0);
        issue(19'h010F, 1'b1, 1'b0, 1'b1, 32'h0);
        check("miss_high.o_wr", 64'(rsp_wr), 64'd0);
        issue(19'h00FF, 1'b1, 1'b0, 1'b1, 32'h0);
        check("miss_low.o_wr", 64'(rsp_wr), 64'd0);
        read_chk("cmd_cnt_b", 19'h010C, 32'd9);

        // Illegal command
        issue(19'h0100, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        check("illegal.o_wr", 64'(rsp_wr), 64'd0);
        read_chk("illegal.shadow", 19'h0100, 32'h0);
        read_chk("illegal.err", 19'h010D, 32'd2);
        read_chk("illegal.cmd", 19'h010C, 32'd13);
        write_reg(19'h010D, 32'h1234);
        read_chk("err_clr", 19'h010D, 32'd0);

        // Back-to-back reads of all config words
        for (int k = 0; k < 8; k++) begin
            read_chk("b2b", 19'h0100 + 19'(k), (k == 2) ? 32'hA5A5_0001 : 32'h0);
        end
        read_chk("b2b.cmd_cnt", 19'h010C, 32'd24);

        // Reset mid-sequence after an uncommitted write
        write_reg(19'h0103, 32'h0000_BEEF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2.cfg2", 64'(cfg[64 +: 32]), 64'd0);
        check("rst2.o_wr", 64'(rsp_wr), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("rst2.shadow3", 19'h0103, 32'h0);
        read_chk("rst2.shadow2", 19'h0102, 32'h0);
        read_chk("rst2.pending", 19'h010E, 32'h0);
        read_chk("rst2.err", 19'h010D, 32'h0);
        read_chk("rst2.cmd", 19'h010C, 32'd4);
        check("rst2.cfg_all", 64'(|cfg), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
